// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types and encodings for the multicycle RV32I control sequencer.
// Holds the state enum, opcodes, ALU op codes, mux select encodings and the opcode-to-immediate decode.
package multicycle_ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_EXEC_I    = 4'd3,
        S_ALU_WB    = 4'd4,
        S_MEM_ADDR  = 4'd5,
        S_MEM_READ  = 4'd6,
        S_MEM_WB    = 4'd7,
        S_MEM_WRITE = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR      = 4'd11,
        S_JALR_LINK = 4'd12,
        S_LUI       = 4'd13,
        S_AUIPC     = 4'd14,
        S_ILLEGAL   = 4'd15
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_ctrl_t;

    // FUNCT: the operation comes from funct3/funct7_b5 (R and I arithmetic).
    typedef enum logic [1:0] {
        ACLS_ADD   = 2'd0,
        ACLS_SUB   = 2'd1,
        ACLS_FUNCT = 2'd2
    } alu_class_t;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;
    localparam logic [1:0] SRC_A_ZERO   = 2'b11;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALU_OUT = 2'b00;
    localparam logic [1:0] RES_MEM     = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:         imm_src_of = IMM_S;
            OP_BRANCH:        imm_src_of = IMM_B;
            OP_JAL:           imm_src_of = IMM_J;
            OP_LUI, OP_AUIPC: imm_src_of = IMM_U;
            default:          imm_src_of = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Controller <-> datapath/memory bundle: IR fields and ALU flags in, control strobes and mux selects out.
interface multicycle_ctrl_fsm_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       alu_zero;
    logic       alu_lt;
    logic       alu_ltu;
    // mem_read/mem_write are held high until the cycle in which mem_ready=1; that cycle completes the access.
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctrl;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic       reg_write;

    modport master (
        input  opcode, funct3, funct7_b5, alu_zero, alu_lt, alu_ltu, mem_ready,
        output pc_write, ir_write, adr_src, mem_read, mem_write, alu_src_a, alu_src_b,
               alu_ctrl, result_src, imm_src, reg_write
    );

    modport slave (
        output opcode, funct3, funct7_b5, alu_zero, alu_lt, alu_ltu, mem_ready,
        input  pc_write, ir_write, adr_src, mem_read, mem_write, alu_src_a, alu_src_b,
               alu_ctrl, result_src, imm_src, reg_write
    );
endinterface

// File: rtl/multicycle_ctrl_fsm_alu_decoder.sv
// Maps (ALU class, funct3, funct7_b5, R-type flag) to the ALU operation code.
module multicycle_ctrl_fsm_alu_decoder
    import multicycle_ctrl_fsm_pkg::*;
(
    input  alu_class_t alu_class,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    input  logic       is_rtype,
    output alu_ctrl_t  alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_class)
            ACLS_SUB:   alu_ctrl = ALU_SUB;
            ACLS_FUNCT: begin
                case (funct3)
                    // IR[30] in an I-type is immediate data, so ADDI never becomes SUB.
                    3'b000:  alu_ctrl = (is_rtype && funct7_b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_SLTU;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = funct7_b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
            default:    alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I control sequencer, one state per cycle; unsupported opcodes trap to a sticky ILLEGAL state.
// Optional CTRL_PERF_CNT_EN adds cycle_count / instret_count performance counters.
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
`ifdef CTRL_PERF_CNT_EN
#(
    parameter int COUNTER_WIDTH = 32
)
`endif
(
    input  logic                     clk,
    input  logic                     reset,
    multicycle_ctrl_fsm_if.master    bus,
    output logic                     illegal,
    output logic [3:0]               state_dbg
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [COUNTER_WIDTH-1:0] cycle_count,
    output logic [COUNTER_WIDTH-1:0] instret_count
`endif
);

    state_t     state, next_state;
    logic       illegal_q;
    logic       pc_w, ir_w, adr, mr, mw, rw, taken;
    logic [1:0] src_a, src_b, res;
    alu_class_t alu_class;
    alu_ctrl_t  alu_op;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == S_ILLEGAL) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        pc_w = 1'b0; ir_w = 1'b0; adr = 1'b0; mr = 1'b0; mw = 1'b0; rw = 1'b0; taken = 1'b0;
        src_a = SRC_A_PC; src_b = SRC_B_RS2; res = RES_ALU_OUT; alu_class = ACLS_ADD;
        case (state)
            S_FETCH: begin
                mr = 1'b1; src_b = SRC_B_FOUR; res = RES_ALU;
                if (bus.mem_ready) begin
                    ir_w = 1'b1; pc_w = 1'b1; next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                src_a = SRC_A_OLD_PC; src_b = SRC_B_IMM;
                case (bus.opcode)
                    OP_R:               next_state = S_EXEC_R;
                    OP_I:               next_state = S_EXEC_I;
                    OP_LOAD, OP_STORE:  next_state = S_MEM_ADDR;
                    OP_BRANCH:          next_state = S_BRANCH;
                    OP_JAL:             next_state = S_JAL;
                    OP_JALR:            next_state = S_JALR;
                    OP_LUI:             next_state = S_LUI;
                    OP_AUIPC:           next_state = S_AUIPC;
                    default:            next_state = S_ILLEGAL;
                endcase
            end
            S_EXEC_R: begin
                src_a = SRC_A_RS1; src_b = SRC_B_RS2; alu_class = ACLS_FUNCT; next_state = S_ALU_WB;
            end
            S_EXEC_I: begin
                src_a = SRC_A_RS1; src_b = SRC_B_IMM; alu_class = ACLS_FUNCT; next_state = S_ALU_WB;
            end
            S_LUI:   begin src_a = SRC_A_ZERO;   src_b = SRC_B_IMM; next_state = S_ALU_WB; end
            S_AUIPC: begin src_a = SRC_A_OLD_PC; src_b = SRC_B_IMM; next_state = S_ALU_WB; end
            S_ALU_WB: begin rw = 1'b1; next_state = S_FETCH; end
            S_MEM_ADDR: begin
                src_a = SRC_A_RS1; src_b = SRC_B_IMM;
                next_state = (bus.opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                adr = 1'b1; mr = 1'b1;
                if (bus.mem_ready) next_state = S_MEM_WB;
            end
            S_MEM_WB: begin res = RES_MEM; rw = 1'b1; next_state = S_FETCH; end
            S_MEM_WRITE: begin
                adr = 1'b1; mw = 1'b1;
                if (bus.mem_ready) next_state = S_FETCH;
            end
            S_BRANCH: begin
                src_a = SRC_A_RS1; src_b = SRC_B_RS2; alu_class = ACLS_SUB; next_state = S_FETCH;
                case (bus.funct3)
                    3'b000:  taken = bus.alu_zero;
                    3'b001:  taken = !bus.alu_zero;
                    3'b100:  taken = bus.alu_lt;
                    3'b101:  taken = !bus.alu_lt;
                    3'b110:  taken = bus.alu_ltu;
                    3'b111:  taken = !bus.alu_ltu;
                    default: next_state = S_ILLEGAL;
                endcase
                pc_w = taken;
            end
            // Target (alu_out from DECODE) goes to PC while the ALU forms old_pc+4 for the link.
            S_JAL: begin
                pc_w = 1'b1; src_a = SRC_A_OLD_PC; src_b = SRC_B_FOUR; next_state = S_ALU_WB;
            end
            S_JALR: begin
                src_a = SRC_A_RS1; src_b = SRC_B_IMM; res = RES_ALU; pc_w = 1'b1; next_state = S_JALR_LINK;
            end
            S_JALR_LINK: begin
                src_a = SRC_A_OLD_PC; src_b = SRC_B_FOUR; res = RES_ALU; rw = 1'b1; next_state = S_FETCH;
            end
            S_ILLEGAL: next_state = S_ILLEGAL;
            default:   next_state = S_FETCH;
        endcase
    end

    multicycle_ctrl_fsm_alu_decoder u_alu_decoder (
        .alu_class (alu_class),
        .funct3    (bus.funct3),
        .funct7_b5 (bus.funct7_b5),
        .is_rtype  (state == S_EXEC_R),
        .alu_ctrl  (alu_op)
    );

    // Reset masks every output combinationally so an in-flight store drops its strobe at once.
    assign bus.pc_write   = reset & pc_w;
    assign bus.ir_write   = reset & ir_w;
    assign bus.adr_src    = reset & adr;
    assign bus.mem_read   = reset & mr;
    assign bus.mem_write  = reset & mw;
    assign bus.reg_write  = reset & rw;
    assign bus.alu_src_a  = reset ? src_a : 2'b00;
    assign bus.alu_src_b  = reset ? src_b : 2'b00;
    assign bus.result_src = reset ? res : 2'b00;
    assign bus.alu_ctrl   = reset ? alu_op : 4'd0;
    assign bus.imm_src    = reset ? imm_src_of(bus.opcode) : 3'd0;
    assign illegal        = reset & illegal_q;
    assign state_dbg      = reset ? state : 4'd0;

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            if (state != S_ILLEGAL) cycle_count <= cycle_count + COUNTER_WIDTH'(1);
            if (state != S_FETCH && next_state == S_FETCH) instret_count <= instret_count + COUNTER_WIDTH'(1);
        end
    end
`endif

endmodule
